rt_cross_clk_de_rx_arb: RTL and testbench
=========================================

# rt_cross_clk_de_rx_arb

Multi-channel receive side of the toggle-handshake data-enable crossing: accepts NCH independent request toggles and data words launched from foreign clock domains, synchronises them into the local clock, buffers one word per channel, and serialises them round-robin onto a single valid/ready stream tagged with channel number. A per-channel acknowledge toggle is returned to each sender, which synchronises it back to form its own busy flag. Sits at the ingress of a block that collects control/status events from several clock domains.

## Interface
- NCH, 4, number of source channels (1..32)
- DWIDTH, 8, data width per channel
- SYNC_STAGES, 2, synchroniser flops per request toggle (minimum 2)
- CHW (localparam), max(1, clog2(NCH)), channel index width
- rt_i_clk  in  1  local clock
- rt_i_rst_n  in  1  reset, asynchronous, active-low
- rt_i_tog_async  in  NCH  request toggles from sender domains (timing-ignored path)
- rt_i_din_async  in  NCH*DWIDTH  sender data; channel c at [c*DWIDTH +: DWIDTH], stable from toggle change until ack toggle returns
- rt_o_ack_tog  out  NCH  acknowledge toggles, one per channel, registered
- rt_o_valid  out  1  output word valid
- rt_i_ready  in  1  consumer accepts when rt_o_valid & rt_i_ready
- rt_o_data  out  DWIDTH  output word
- rt_o_ch  out  CHW  source channel of rt_o_data
- rt_o_pend  out  NCH  per-channel slot-occupied mask
- rt_o_err_proto  out  1  sticky protocol-violation flag

## Operation
- Per channel: SYNC_STAGES-deep shift chain on rt_i_tog_async[c], plus one history flop; event[c] = last stage XOR history.
- On event[c]: slot[c] <= din of channel c, pend[c] <= 1.
- Output register empty, or emptied this cycle by handshake: select first pend channel scanning rr_ptr+1, rr_ptr+2, ... with wrap at NCH-1 -> 0; load rt_o_data/rt_o_ch from that slot, set rt_o_valid, clear pend of that channel, rr_ptr <= selected channel.
- No pend set and handshake occurs: rt_o_valid <= 0.
- rt_o_valid held with rt_o_data/rt_o_ch stable until accepted; no withdrawal.
- On handshake: rt_o_ack_tog[rt_o_ch] inverts. Sender may launch the next request only after seeing ack change, so one outstanding word per channel.
- Event on channel c in the same cycle as pend[c] being cleared by selection: selection uses old slot, new event sets pend and slot (only reachable under protocol violation).
- Reset (asynchronous, any time, including mid-transfer): sync chains, history, slots, pend, rt_o_ack_tog, rt_o_valid, rt_o_data, rt_o_ch, rt_o_err_proto all 0; rr_ptr = NCH-1 so channel 0 has first priority. Senders are reset together; toggles start at 0.

## Timing
- Toggle change sampled at clock edge 1 -> pend set at edge SYNC_STAGES+1 -> rt_o_valid high after edge SYNC_STAGES+2 (output empty); latency SYNC_STAGES+2 cycles.
- Sustained throughput one word per cycle with rt_i_ready held high and multiple channels pending.
- Ack toggle changes at the edge completing the handshake.
- Fairness: with all NCH channels pending continuously, each granted exactly once per NCH grants.

## Configuration
- RT_CROSS_CLK_DE_RX_PROTO_CHK_EN defined: event[c] while pend[c]=1, or while rt_o_valid=1 with rt_o_ch=c, sets rt_o_err_proto (sticky until reset); new data is dropped, held slot/output unchanged.
- Not defined: rt_o_err_proto tied 0; such an event overwrites slot[c] (last wins) and sets pend[c].

## Test plan
- NCH=4, SYNC_STAGES=2: toggle ch2 with din=0xA5, ready=1 -> rt_o_valid after 4 cycles, data 0xA5, ch 2, one-cycle pulse; ack_tog[2] 0->1.
- Toggle all four channels same cycle, ready=1 -> outputs ch0,1,2,3 on four consecutive cycles; each ack toggles once.
- ready=0 for 10 cycles with ch1 pending -> valid/data/ch held stable, ack_tog[1] unchanged; ready=1 -> accepted, ack toggles.
- After grant of ch1, ch0 and ch3 both pending -> ch3 granted before ch0 (round-robin wrap).
- With macro: toggle ch0 twice without waiting for ack, ready=0 -> rt_o_err_proto=1, output keeps first word; without macro: err stays 0.
- Assert rt_i_rst_n low while valid=1 and pend=4'b0110 -> all outputs 0 immediately; after release, ch0 request serviced first.

Source files
------------

// File: rtl/rt_cross_clk_de_rx_arb.sv
// Multi-channel toggle-handshake receiver: synchronises per-channel request toggles,
// buffers one word per channel and serialises round-robin. Optional check: RT_CROSS_CLK_DE_RX_PROTO_CHK_EN.
module rt_cross_clk_de_rx_arb #(
    parameter  int NCH         = 4,
    parameter  int DWIDTH      = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    rt_i_clk,
    input  logic                    rt_i_rst_n,
    input  logic [NCH-1:0]          rt_i_tog_async,
    input  logic [NCH*DWIDTH-1:0]   rt_i_din_async,
    output logic [NCH-1:0]          rt_o_ack_tog,
    output logic                    rt_o_valid,
    input  logic                    rt_i_ready,
    output logic [DWIDTH-1:0]       rt_o_data,
    output logic [CHW-1:0]          rt_o_ch,
    output logic [NCH-1:0]          rt_o_pend,
    output logic                    rt_o_err_proto
);

    logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NCH-1:0]                  hist_q;
    logic [NCH-1:0]                  evt;
    logic [NCH-1:0][DWIDTH-1:0]      slot_q, slot_d;
    logic [NCH-1:0]                  pend_q, pend_d;
    logic [NCH-1:0]                  ack_q, ack_d;
    logic                            valid_q, valid_d;
    logic [DWIDTH-1:0]               data_q, data_d;
    logic [CHW-1:0]                  ch_q, ch_d;
    logic [CHW-1:0]                  rr_q, rr_d;
    logic                            hs;
    logic                            found;
    logic [CHW-1:0]                  sel;
    logic [CHW-1:0]                  cand;
`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
    logic                            err_q, err_d;
`endif

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            evt[c] = sync_q[c][SYNC_STAGES-1] ^ hist_q[c];
        end
    end

    assign hs = valid_q & rt_i_ready;

    // First pending channel after the last grant, wrapping at NCH-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = CHW'((32'(rr_q) + i) % NCH);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        slot_d  = slot_q;
        pend_d  = pend_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
        err_d   = err_q;
`endif

        if (!valid_q || hs) begin
            if (found) begin
                valid_d      = 1'b1;
                data_d       = slot_q[sel];
                ch_d         = sel;
                pend_d[sel]  = 1'b0;
                rr_d         = sel;
            end else begin
                valid_d      = 1'b0;
            end
        end

        if (hs) begin
            ack_d[ch_q] = ~ack_q[ch_q];
        end

        // Events are applied after selection so a same-cycle event re-arms the slot.
        for (int unsigned c = 0; c < NCH; c++) begin
            if (evt[c]) begin
`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
                if (pend_q[c] || (valid_q && (ch_q == CHW'(c)))) begin
                    err_d = 1'b1;
                end else begin
                    slot_d[c] = rt_i_din_async[c*DWIDTH +: DWIDTH];
                    pend_d[c] = 1'b1;
                end
`else
                slot_d[c] = rt_i_din_async[c*DWIDTH +: DWIDTH];
                pend_d[c] = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
        if (!rt_i_rst_n) begin
            sync_q  <= '0;
            hist_q  <= '0;
            slot_q  <= '0;
            pend_q  <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            rr_q    <= CHW'(NCH - 1);
`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], rt_i_tog_async[c]};
                hist_q[c] <= sync_q[c][SYNC_STAGES-1];
            end
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rt_o_ack_tog = ack_q;
    assign rt_o_valid   = valid_q;
    assign rt_o_data    = data_q;
    assign rt_o_ch      = ch_q;
    assign rt_o_pend    = pend_q;
`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
    assign rt_o_err_proto = err_q;
`else
    assign rt_o_err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_rt_cross_clk_de_rx_arb.sv
// Bench for rt_cross_clk_de_rx_arb: vector table plus hand sequences, output scoreboard.
module tb_rt_cross_clk_de_rx_arb;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int CHW = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      tog;
    logic [NCH*DW-1:0]   din;
    logic                ready;
    logic [NCH-1:0]      ack;
    logic                valid;
    logic [DW-1:0]       data;
    logic [CHW-1:0]      ch;
    logic [NCH-1:0]      pend;
    logic                err;

    rt_cross_clk_de_rx_arb #(.NCH(NCH), .DWIDTH(DW), .SYNC_STAGES(SS)) dut (
        .rt_i_clk       (clk),
        .rt_i_rst_n     (rst_n),
        .rt_i_tog_async (tog),
        .rt_i_din_async (din),
        .rt_o_ack_tog   (ack),
        .rt_o_valid     (valid),
        .rt_i_ready     (ready),
        .rt_o_data      (data),
        .rt_o_ch        (ch),
        .rt_o_pend      (pend),
        .rt_o_err_proto (err)
    );

    always #5 clk = ~clk;

`ifdef RT_CROSS_CLK_DE_RX_PROTO_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
    } item_t;

    typedef struct {
        int unsigned    ch;
        logic [DW-1:0]  data;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    item_t       sbq[$];
    logic [NCH-1:0] exp_ack;
    vec_t        vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: score any handshake about to happen, then check the ack toggles.
    task automatic step();
        item_t it;
        if (valid === 1'b1 && ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual ch=%0d data=%0h required none", ch, data);
            end else begin
                it = sbq.pop_front();
                chk("out_ch", 32'(ch), 32'(it.ch));
                chk("out_data", 32'(data), 32'(it.data));
                exp_ack[it.ch] = ~exp_ack[it.ch];
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("ack_tog", 32'(ack), 32'(exp_ack));
    endtask

    task automatic send(input int unsigned c, input logic [DW-1:0] d);
        din[c*DW +: DW] = d;
        tog[c]          = ~tog[c];
    endtask

    task automatic expect_out(input int unsigned c, input logic [DW-1:0] d);
        item_t it;
        it.ch   = CHW'(c);
        it.data = d;
        sbq.push_back(it);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ch", 32'(ch), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tog     = '0;
        din     = '0;
        exp_ack = '0;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{ch: 2, data: 8'hA5};
        vecs[1] = '{ch: 0, data: 8'h3C};
        vecs[2] = '{ch: 3, data: 8'hFF};
        vecs[3] = '{ch: 1, data: 8'h00};

        rst_n   = 1'b1;
        tog     = '0;
        din     = '0;
        ready   = 1'b0;
        exp_ack = '0;
        @(negedge clk);
        do_reset();

        // Single-channel latency and one-cycle pulse.
        ready = 1'b1;
        foreach (vecs[v]) begin
            send(vecs[v].ch, vecs[v].data);
            expect_out(vecs[v].ch, vecs[v].data);
            for (int k = 1; k <= 4; k++) begin
                step();
                chk("lat_valid", 32'(valid), (k == 4) ? 32'd1 : 32'd0);
            end
            step();
            chk("pulse_valid", 32'(valid), 32'd0);
        end

        // All four at once from reset: ch0..3 back to back.
        @(negedge clk);
        do_reset();
        ready = 1'b1;
        for (int unsigned c = 0; c < NCH; c++) begin
            send(c, DW'(8'h10 + c));
            expect_out(c, DW'(8'h10 + c));
        end
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("burst_valid", 32'(valid), 32'd1);
            chk("burst_ch", 32'(ch), 32'(k));
        end
        step();
        chk("burst_end", 32'(valid), 32'd0);
        chk("burst_q", 32'(sbq.size()), 32'd0);

        // Backpressure hold on ch1, then round-robin wrap to ch3 before ch0.
        ready = 1'b0;
        send(1, 8'h5A);
        expect_out(1, 8'h5A);
        for (int k = 0; k < 4; k++) step();
        send(0, 8'h0F);
        send(3, 8'hF0);
        expect_out(3, 8'hF0);
        expect_out(0, 8'h0F);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_data", 32'(data), 32'h5A);
            chk("hold_ch", 32'(ch), 32'd1);
        end
        chk("hold_pend", 32'(pend), 32'b1001);
        ready = 1'b1;
        drain();

        // Second toggle on ch0 before its ack.
        ready = 1'b0;
        send(0, 8'h11);
        expect_out(0, 8'h11);
        for (int k = 0; k < 5; k++) step();
        chk("proto_first", 32'(data), 32'h11);
        send(0, 8'h22);
        if (!CHK_EN) expect_out(0, 8'h22);
        for (int k = 0; k < 5; k++) step();
        chk("proto_err", 32'(err), 32'(CHK_EN));
        chk("proto_data", 32'(data), 32'h11);
        chk("proto_ch", 32'(ch), 32'd0);
        chk("proto_pend", 32'(pend), CHK_EN ? 32'd0 : 32'd1);
        ready = 1'b1;
        drain();
        chk("proto_err_sticky", 32'(err), 32'(CHK_EN));

        // Reset mid-transfer with output held and ch1/ch2 pending.
        ready = 1'b0;
        send(3, 8'h33);
        expect_out(3, 8'h33);
        for (int k = 0; k < 5; k++) step();
        send(1, 8'h44);
        send(2, 8'h55);
        for (int k = 0; k < 4; k++) step();
        chk("mid_valid", 32'(valid), 32'd1);
        chk("mid_pend", 32'(pend), 32'b0110);
        do_reset();
        ready = 1'b1;
        send(3, 8'hA3);
        send(1, 8'hA1);
        send(0, 8'hA0);
        expect_out(0, 8'hA0);
        expect_out(1, 8'hA1);
        expect_out(3, 8'hA3);
        drain();
        step();
        chk("final_valid", 32'(valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
